cnt_up_down: RTL and testbench



---
 rtl/cnt_up_down.sv | 71 +++++++
 tb/tb_cnt_up_down.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cnt_up_down.sv
// rtl/cnt_up_down.sv - up/down counter with synchronous clear, wrap or saturate at limits
//
// Ports:
//   Clock - rising-edge system clock
//   Reset - synchronous active-high clear, overrides Up/Down
//   Up    - increment request
//   Down  - decrement request
//   Count - current count, straight from the count register
//
// Parameters:
//   WIDTH - counter width in bits
//   WRAP  - 1: modulo wrap at the limits, 0: saturate at the limits

module cnt_up_down #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Up,
    input  logic             Down,
    output logic [WIDTH-1:0] Count
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_dec;
    logic [WIDTH-1:0] cnt_next;

    assign at_max  = (Count == CNT_MAX);
    assign at_zero = (Count == CNT_ZERO);

    // Limit handling: in wrap mode the plain modulo sum already rolls over,
    // in saturate mode the count sticks at the limit it would cross.
    always_comb begin
        cnt_inc = Count + CNT_ONE;
        cnt_dec = Count - CNT_ONE;
        if (!WRAP && at_max) begin
            cnt_inc = CNT_MAX;
        end
        if (!WRAP && at_zero) begin
            cnt_dec = CNT_ZERO;
        end
    end

    // Only an exact 10 or 01 moves the count. 11 cancels, 00 holds, and any
    // X/Z on the strobes fails both case items and falls through to hold.
    always_comb begin
        cnt_next = Count;
        case ({Up, Down})
            2'b10:   cnt_next = cnt_inc;
            2'b01:   cnt_next = cnt_dec;
            default: cnt_next = Count;
        endcase
    end

    // Reset is tested first so a clear never depends on the strobe values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count <= CNT_ZERO;
        end else begin
            Count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_cnt_up_down.sv
// tb/tb_cnt_up_down.sv - directed self-checking bench for cnt_up_down in wrap and saturate modes

module tb_cnt_up_down;

    logic       clk = 1'b0;
    logic       w_reset, w_up, w_down;
    logic       s_reset, s_up, s_down;
    logic [3:0] w_count, s_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cnt_up_down #(.WIDTH(4), .WRAP(1'b1)) dut_wrap (
        .Clock (clk),
        .Reset (w_reset),
        .Up    (w_up),
        .Down  (w_down),
        .Count (w_count)
    );

    cnt_up_down #(.WIDTH(4), .WRAP(1'b0)) dut_sat (
        .Clock (clk),
        .Reset (s_reset),
        .Up    (s_up),
        .Down  (s_down),
        .Count (s_count)
    );

    task automatic tick_w(input logic r, input logic u, input logic d);
        @(negedge clk);
        w_reset = r;
        w_up    = u;
        w_down  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_s(input logic r, input logic u, input logic d);
        @(negedge clk);
        s_reset = r;
        s_up    = u;
        s_down  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        w_reset = 1'b0; w_up = 1'b0; w_down = 1'b0;
        s_reset = 1'b0; s_up = 1'b0; s_down = 1'b0;

        // Reset held with Up=1 for 5 cycles: count stays 0
        for (int i = 0; i < 5; i++) begin
            tick_w(1'b1, 1'b1, 1'b0);
            chk("reset_hold_up", w_count, 4'd0);
        end
        tick_w(1'b0, 1'b0, 1'b0);
        chk("reset_release_idle", w_count, 4'd0);

        // Count up 17 cycles: 1..15,0,1
        for (int i = 0; i < 17; i++) begin
            logic [3:0] e;
            e = 4'((i + 1) % 16);
            tick_w(1'b0, 1'b1, 1'b0);
            chk("wrap_up", w_count, e);
        end

        // Back to 0, then count down 3 cycles: 15,14,13
        tick_w(1'b1, 1'b0, 1'b0);
        chk("reset_again", w_count, 4'd0);
        tick_w(1'b0, 1'b0, 1'b1);
        chk("wrap_down_15", w_count, 4'd15);
        tick_w(1'b0, 1'b0, 1'b1);
        chk("wrap_down_14", w_count, 4'd14);
        tick_w(1'b0, 1'b0, 1'b1);
        chk("wrap_down_13", w_count, 4'd13);

        // 13 + 10 steps up wraps to 7
        for (int i = 0; i < 10; i++) tick_w(1'b0, 1'b1, 1'b0);
        chk("reach_7", w_count, 4'd7);

        // Hold: 11 for 3 cycles, 00 for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick_w(1'b0, 1'b1, 1'b1);
            chk("hold_both", w_count, 4'd7);
        end
        for (int i = 0; i < 3; i++) begin
            tick_w(1'b0, 1'b0, 1'b0);
            chk("hold_none", w_count, 4'd7);
        end

        // Unknown strobes with Reset=0 decode as hold
        tick_w(1'b0, 1'bx, 1'b0);
        chk("hold_x_up", w_count, 4'd7);
        tick_w(1'b0, 1'bx, 1'bx);
        chk("hold_x_both", w_count, 4'd7);

        // Single-cycle strobes step once each
        tick_w(1'b0, 1'b1, 1'b0);
        chk("strobe_up_8", w_count, 4'd8);
        tick_w(1'b0, 1'b0, 1'b0);
        chk("strobe_idle_8", w_count, 4'd8);
        tick_w(1'b0, 1'b1, 1'b0);
        chk("strobe_up_9", w_count, 4'd9);

        // Reset mid-count with Up=1 discards the step, next edge counts from 0
        tick_w(1'b1, 1'b1, 1'b0);
        chk("reset_mid", w_count, 4'd0);
        tick_w(1'b0, 1'b1, 1'b0);
        chk("after_reset_up", w_count, 4'd1);

        // Unknown strobes under Reset still clear cleanly
        tick_w(1'b1, 1'bx, 1'bx);
        chk("reset_x_inputs", w_count, 4'd0);

        // Saturating instance: reset, climb to 14
        tick_s(1'b1, 1'b0, 1'b0);
        chk("sat_reset", s_count, 4'd0);
        for (int i = 0; i < 14; i++) tick_s(1'b0, 1'b1, 1'b0);
        chk("sat_reach_14", s_count, 4'd14);
        tick_s(1'b0, 1'b1, 1'b0);
        chk("sat_up_15a", s_count, 4'd15);
        tick_s(1'b0, 1'b1, 1'b0);
        chk("sat_up_15b", s_count, 4'd15);
        tick_s(1'b0, 1'b1, 1'b0);
        chk("sat_up_15c", s_count, 4'd15);

        // Down from 15 by 14 to reach 1, then 3 more: 0,0,0
        for (int i = 0; i < 14; i++) tick_s(1'b0, 1'b0, 1'b1);
        chk("sat_reach_1", s_count, 4'd1);
        tick_s(1'b0, 1'b0, 1'b1);
        chk("sat_down_0a", s_count, 4'd0);
        tick_s(1'b0, 1'b0, 1'b1);
        chk("sat_down_0b", s_count, 4'd0);
        tick_s(1'b0, 1'b0, 1'b1);
        chk("sat_down_0c", s_count, 4'd0);

        // Saturating instance still counts normally off the limit
        tick_s(1'b0, 1'b1, 1'b0);
        chk("sat_up_from_0", s_count, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
